// File: rtl/bus_ctrl_if.sv
// CPU-side request/response and slave-side select/strobe signals of the bus controller.
interface bus_ctrl_if #(
   parameter int unsigned NSLV = 4
);
   logic                   cpu_ce;
   logic [31:0]            cpu_addr;
   logic [31:0]            cpu_wdata;
   logic                   cpu_rd;
   logic                   cpu_wr;
   logic [31:0]            cpu_rdata;
   logic                   cpu_ack;
   logic                   cpu_err;
   logic [NSLV-1:0]        slv_sel;
   logic                   slv_re;
   logic                   slv_we;
   logic [27:0]            slv_addr;
   logic [31:0]            slv_wdata;
   logic [NSLV*32-1:0]     slv_rdata;

   // Controller view: drives the slave bus and answers the CPU.
   modport master (
      input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, slv_rdata,
      output cpu_ce, cpu_rdata, cpu_ack, cpu_err,
             slv_sel, slv_re, slv_we, slv_addr, slv_wdata
   );

   // Environment view: CPU requester plus the addressed slaves.
   modport slave (
      output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, slv_rdata,
      input  cpu_ce, cpu_rdata, cpu_ack, cpu_err,
             slv_sel, slv_re, slv_we, slv_addr, slv_wdata
   );
endinterface

// File: rtl/bus_ctrl.sv
// Bus controller: CPU clock-enable divider, tag-decoded slave access FSM with wait states, sticky write flags.
// Define BUS_CTRL_ERRCNT_EN to build the saturating error counter; otherwise err_cnt is tied to zero.
module bus_ctrl #(
   parameter int unsigned DIV_LOG2 = 3,
   parameter int unsigned NSLV     = 4,
   parameter logic [3:0]  BASE_TAG = 4'h0,
   parameter int unsigned WAIT_CYC = 1
) (
   input  logic             clk_50mhz,
   input  logic             rst,
   bus_ctrl_if.master       bus,
   input  logic             led_clr,
   output logic [NSLV-1:0]  wr_seen,
   output logic             busy,
   output logic [7:0]       err_cnt
);
   localparam int unsigned DW        = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'((64'd1 << DIV_LOG2) - 64'd1);
   localparam logic [3:0] WAIT_LAST  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_RESP} state_t;

   state_t            r_state, w_state_nxt;
   logic [DW-1:0]     r_div, w_div_nxt;
   logic              r_ce;
   logic [3:0]        r_idx, w_idx_nxt;
   logic              r_wr, w_wr_nxt;
   logic [3:0]        r_wcnt, w_wcnt_nxt;
   logic              r_ack, w_ack_nxt;
   logic              r_err, w_err_nxt;
   logic [31:0]       r_rdata, w_rdata_nxt;
   logic [NSLV-1:0]   r_sel, w_sel_nxt;
   logic              r_re, w_re_nxt;
   logic              r_we, w_we_nxt;
   logic [27:0]       r_addr, w_addr_nxt;
   logic [31:0]       r_wdata, w_wdata_nxt;
   logic [NSLV-1:0]   r_wr_seen, w_set_seen;
   logic              r_busy;
   logic              w_err_evt;
   logic [4:0]        w_tag_off;
   logic              w_mapped;
   logic [31:0]       w_slice;

   assign w_div_nxt = (r_div == DIV_MAX) ? '0 : r_div + DW'(1);
   assign w_tag_off = 5'(bus.cpu_addr[31:28]) - 5'(BASE_TAG);
   assign w_mapped  = (bus.cpu_addr[31:28] >= BASE_TAG) && (w_tag_off < 5'(NSLV));

   // Read data of the slave currently being accessed.
   always_comb begin
      w_slice = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (r_idx == 4'(k)) w_slice = bus.slv_rdata[32*k +: 32];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_nxt    = r_wr;
      w_wcnt_nxt  = r_wcnt;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = r_rdata;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_set_seen  = '0;
      w_err_evt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_ce && (bus.cpu_rd || bus.cpu_wr)) begin
               if ((bus.cpu_rd ^ bus.cpu_wr) && w_mapped) begin
                  w_idx_nxt   = w_tag_off[3:0];
                  w_wr_nxt    = bus.cpu_wr;
                  w_addr_nxt  = bus.cpu_addr[27:0];
                  w_wdata_nxt = bus.cpu_wdata;
                  w_state_nxt = S_ACC;
               end else begin
                  w_state_nxt = S_RESP;
                  w_err_nxt   = 1'b1;
                  w_err_evt   = 1'b1;
                  if (bus.cpu_rd) w_rdata_nxt = '0;
               end
            end
         end
         S_ACC: begin
            if (r_wr) w_set_seen = NSLV'(1) << r_idx;
            if (WAIT_CYC == 0) begin
               w_state_nxt = S_RESP;
               if (!r_wr) w_rdata_nxt = w_slice;
            end else begin
               w_state_nxt = S_WAIT;
               w_wcnt_nxt  = '0;
            end
         end
         S_WAIT: begin
            if (r_wcnt == WAIT_LAST) begin
               w_state_nxt = S_RESP;
               if (!r_wr) w_rdata_nxt = w_slice;
            end else begin
               w_wcnt_nxt = r_wcnt + 4'd1;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      // Bus outputs are registered and track the state being entered.
      w_sel_nxt = ((w_state_nxt == S_ACC) || (w_state_nxt == S_WAIT)) ? (NSLV'(1) << w_idx_nxt) : '0;
      w_re_nxt  = (w_state_nxt == S_ACC) && !w_wr_nxt;
      w_we_nxt  = (w_state_nxt == S_ACC) && w_wr_nxt;
      w_ack_nxt = (w_state_nxt == S_RESP);
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_ce      <= 1'b0;
         r_idx     <= '0;
         r_wr      <= 1'b0;
         r_wcnt    <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
         r_sel     <= '0;
         r_re      <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wr_seen <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_ce      <= (w_div_nxt == DIV_MAX);
         r_idx     <= w_idx_nxt;
         r_wr      <= w_wr_nxt;
         r_wcnt    <= w_wcnt_nxt;
         r_ack     <= w_ack_nxt;
         r_err     <= w_err_nxt;
         r_rdata   <= w_rdata_nxt;
         r_sel     <= w_sel_nxt;
         r_re      <= w_re_nxt;
         r_we      <= w_we_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         // A write landing on the same edge as led_clr keeps its flag.
         r_wr_seen <= (r_wr_seen & ~{NSLV{led_clr}}) | w_set_seen;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

`ifdef BUS_CTRL_ERRCNT_EN
   logic [7:0] r_err_cnt;
   always_ff @(posedge clk_50mhz) begin
      if (rst)                                 r_err_cnt <= '0;
      else if (w_err_evt && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
   end
   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = 8'h00;
`endif

   assign bus.cpu_ce    = r_ce;
   assign bus.cpu_rdata = r_rdata;
   assign bus.cpu_ack   = r_ack;
   assign bus.cpu_err   = r_err;
   assign bus.slv_sel   = r_sel;
   assign bus.slv_re    = r_re;
   assign bus.slv_we    = r_we;
   assign bus.slv_addr  = r_addr;
   assign bus.slv_wdata = r_wdata;
   assign wr_seen       = r_wr_seen;
   assign busy          = r_busy;
endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: transaction-level reference model, directed and random accesses.
module tb_bus_ctrl;
   localparam int unsigned NSLV = 4;
   localparam int unsigned WC   = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, led_clr, led_clr2;
   logic [3:0] ws1, ws2;
   logic       busy1, busy2;
   logic [7:0] ec1, ec2;

   bus_ctrl_if #(.NSLV(NSLV)) b1 ();
   bus_ctrl_if #(.NSLV(NSLV)) b2 ();

   bus_ctrl #(.DIV_LOG2(3), .NSLV(NSLV), .BASE_TAG(4'h0), .WAIT_CYC(WC)) dut (
      .clk_50mhz(clk), .rst(rst), .bus(b1.master), .led_clr(led_clr),
      .wr_seen(ws1), .busy(busy1), .err_cnt(ec1));

   bus_ctrl #(.DIV_LOG2(0), .NSLV(NSLV), .BASE_TAG(4'h0), .WAIT_CYC(0)) dut2 (
      .clk_50mhz(clk), .rst(rst), .bus(b2.master), .led_clr(led_clr2),
      .wr_seen(ws2), .busy(busy2), .err_cnt(ec2));

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] slv_mem [NSLV];
   logic [31:0] m_rdata = '0;
   logic [3:0]  m_seen = '0;
   int          m_errs = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_errcnt(input int n);
`ifdef BUS_CTRL_ERRCNT_EN
      return (n > 255) ? 32'd255 : 32'(n);
`else
      return 32'(n - n);
`endif
   endfunction

   task automatic wait_ce_idle();
      int guard = 0;
      while (!(b1.cpu_ce === 1'b1 && busy1 === 1'b0) && guard < 64) begin
         tick();
         guard++;
      end
      chk("ce_wait_bound", 32'(guard < 64), 32'd1);
   endtask

   // One CPU access on dut; checks strobes, select, latency, response and write flags.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic clr_acc);
      int   tag, ack_j, n_re, n_we;
      bit   legal, sel_ok, clr_eff;
      logic [3:0] exp_sel, onehot;
      logic [31:0] got_rdata;
      logic got_err;
      tag     = int'(addr[31:28]);
      legal   = (rd != wr) && (tag < int'(NSLV));
      onehot  = legal ? 4'(1 << tag) : 4'h0;
      clr_eff = clr_acc && legal;
      ack_j = -1; n_re = 0; n_we = 0; sel_ok = 1'b1; got_rdata = '0; got_err = 1'b0;
      b1.slv_rdata = {slv_mem[3], slv_mem[2], slv_mem[1], slv_mem[0]};
      wait_ce_idle();
      b1.cpu_rd = rd; b1.cpu_wr = wr; b1.cpu_addr = addr; b1.cpu_wdata = wdata;
      for (int j = 0; j < 32; j++) begin
         tick();
         if (j == 1) led_clr = 1'b0;
         if (b1.slv_re === 1'b1) n_re++;
         if (b1.slv_we === 1'b1) n_we++;
         exp_sel = (legal && j <= int'(WC)) ? onehot : 4'h0;
         if (b1.slv_sel !== exp_sel) sel_ok = 1'b0;
         if (j == 0) chk("busy_in_access", 32'(busy1), 32'd1);
         if (legal && j == 0) begin
            chk("slv_addr", 32'(b1.slv_addr), 32'(addr[27:0]));
            if (wr) chk("slv_wdata", b1.slv_wdata, wdata);
         end
         if (b1.cpu_ack === 1'b1) begin
            ack_j = j; got_rdata = b1.cpu_rdata; got_err = b1.cpu_err;
            break;
         end
         if (j == 0 && clr_eff) led_clr = 1'b1;
      end
      b1.cpu_rd = 1'b0; b1.cpu_wr = 1'b0;
      if (legal && rd) m_rdata = slv_mem[tag];
      if (!legal && rd) m_rdata = '0;
      if (!legal) m_errs++;
      if (clr_eff) m_seen = wr ? onehot : 4'h0;
      else if (legal && wr) m_seen = m_seen | onehot;
      chk("ack_latency", 32'(ack_j), legal ? 32'(WC + 1) : 32'd0);
      chk("cpu_err", 32'(got_err), 32'(!legal));
      chk("cpu_rdata", got_rdata, m_rdata);
      chk("re_count", 32'(n_re), 32'(legal && rd));
      chk("we_count", 32'(n_we), 32'(legal && wr));
      chk("sel_pattern", 32'(sel_ok), 32'd1);
      tick();
      chk("wr_seen", 32'(ws1), 32'(m_seen));
      chk("busy_after", 32'(busy1), 32'd0);
      chk("ack_single", 32'(b1.cpu_ack), 32'd0);
   endtask

   task automatic check_ce_after_release();
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("ce_period", 32'(b1.cpu_ce), 32'((i % 8) == 7));
         chk("ce_div0", 32'(b2.cpu_ce), 32'd1);
      end
   endtask

   initial begin
      int n_re, n_ack, r;
      logic [31:0] a;
      rst = 1'b1; led_clr = 1'b0; led_clr2 = 1'b0;
      b1.cpu_rd = 1'b0; b1.cpu_wr = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0; b1.slv_rdata = '0;
      b2.cpu_rd = 1'b0; b2.cpu_wr = 1'b0; b2.cpu_addr = '0; b2.cpu_wdata = '0; b2.slv_rdata = '0;
      for (int k = 0; k < int'(NSLV); k++) slv_mem[k] = $urandom;
      repeat (3) tick();
      chk("rst_ce", 32'(b1.cpu_ce), 32'd0);
      chk("rst_ce_div0", 32'(b2.cpu_ce), 32'd0);
      chk("rst_ack", 32'(b1.cpu_ack), 32'd0);
      chk("rst_err", 32'(b1.cpu_err), 32'd0);
      chk("rst_rdata", b1.cpu_rdata, 32'd0);
      chk("rst_sel", 32'(b1.slv_sel), 32'd0);
      chk("rst_strobes", 32'({b1.slv_re, b1.slv_we}), 32'd0);
      chk("rst_addr", 32'(b1.slv_addr), 32'd0);
      chk("rst_wdata", b1.slv_wdata, 32'd0);
      chk("rst_wr_seen", 32'(ws1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_err_cnt", 32'(ec1), 32'd0);
      rst = 1'b0;
      check_ce_after_release();

      // Divide-by-1, zero-wait instance: read acked on the second edge after sampling
      b2.slv_rdata = {32'h0, 32'h0, 32'h0BAD_F00D, 32'h0};
      b2.cpu_rd = 1'b1; b2.cpu_addr = 32'h1000_0000;
      tick();
      chk("d0_re", 32'(b2.slv_re), 32'd1);
      chk("d0_sel", 32'(b2.slv_sel), 32'h2);
      tick();
      b2.cpu_rd = 1'b0;
      chk("d0_ack", 32'(b2.cpu_ack), 32'd1);
      chk("d0_err", 32'(b2.cpu_err), 32'd0);
      chk("d0_rdata", b2.cpu_rdata, 32'h0BAD_F00D);
      tick();
      chk("d0_ack_off", 32'(b2.cpu_ack), 32'd0);

      // Directed transactions
      slv_mem[2] = 32'h1234_5678;
      access(1'b1, 1'b0, 32'h2000_0010, 32'h0, 1'b0);
      access(1'b0, 1'b1, 32'h1000_0004, 32'hCAFE_F00D, 1'b0);
      access(1'b0, 1'b1, 32'h1000_0008, 32'h5555_AAAA, 1'b1);
      led_clr = 1'b1; tick(); led_clr = 1'b0; m_seen = '0;
      chk("led_clr_idle", 32'(ws1), 32'd0);
      access(1'b1, 1'b0, 32'hA000_0000, 32'h0, 1'b0);
      access(1'b0, 1'b1, 32'h3000_0000, 32'h1, 1'b0);
      access(1'b1, 1'b1, 32'h0000_0000, 32'h2, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < int'(NSLV); k++) slv_mem[k] = $urandom;
         r = int'($urandom_range(0, 9));
         a = $urandom;
         access(r <= 4 || r == 9, r >= 5, a, $urandom, $urandom_range(0, 3) == 0);
      end

      // Held request: one access per clock-enable sample, no queueing
      slv_mem[3] = 32'hFEED_0003;
      b1.slv_rdata = {slv_mem[3], slv_mem[2], slv_mem[1], slv_mem[0]};
      wait_ce_idle();
      b1.cpu_rd = 1'b1; b1.cpu_addr = 32'h3000_0020;
      n_re = 0; n_ack = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         if (b1.slv_re === 1'b1) n_re++;
         if (b1.cpu_ack === 1'b1) n_ack++;
      end
      b1.cpu_rd = 1'b0;
      m_rdata = slv_mem[3];
      chk("held_re", 32'(n_re), 32'd4);
      chk("held_ack", 32'(n_ack), 32'd4);
      chk("held_rdata", b1.cpu_rdata, m_rdata);
      repeat (4) tick();

      // Error counter over many unmapped accesses
      for (int i = 0; i < 300; i++) access(1'b1, 1'b0, 32'hB000_0000 | 32'(i), 32'h0, 1'b0);
      chk("err_cnt", 32'(ec1), exp_errcnt(m_errs));

      // Reset during a wait state aborts the access
      slv_mem[3] = 32'h7777_0000;
      b1.slv_rdata = {slv_mem[3], slv_mem[2], slv_mem[1], slv_mem[0]};
      wait_ce_idle();
      b1.cpu_rd = 1'b1; b1.cpu_addr = 32'h3000_0000;
      tick();
      tick();
      chk("in_wait_sel", 32'(b1.slv_sel), 32'h8);
      rst = 1'b1;
      tick();
      rst = 1'b0; b1.cpu_rd = 1'b0;
      m_rdata = '0; m_seen = '0; m_errs = 0;
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_sel", 32'(b1.slv_sel), 32'd0);
      chk("abort_ack", 32'(b1.cpu_ack), 32'd0);
      chk("abort_re", 32'(b1.slv_re), 32'd0);
      chk("abort_rdata", b1.cpu_rdata, m_rdata);
      chk("abort_err_cnt", 32'(ec1), exp_errcnt(m_errs));
      check_ce_after_release();
      chk("abort_no_late_ack", 32'(b1.cpu_ack), 32'd0);
      access(1'b0, 1'b1, 32'h0000_0100, 32'h1357_9BDF, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
